// File: rtl/up_regs_pkg.sv
// rtl/up_regs_pkg.sv - shared types and constants for the copy-engine register block
package up_regs_pkg;

  localparam int UP_ADDR_WIDTH = 32;
  localparam int UP_SIZE_WIDTH = 16;

  localparam logic [4:0] REG_SRC    = 5'h00;
  localparam logic [4:0] REG_DST    = 5'h04;
  localparam logic [4:0] REG_SIZE   = 5'h08;
  localparam logic [4:0] REG_CTRL   = 5'h0C;
  localparam logic [4:0] REG_CMD    = 5'h10;
  localparam logic [4:0] REG_STATUS = 5'h14;

  localparam int CMD_PUSH    = 0;
  localparam int CMD_CLR_INT = 1;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_INT_PEND  = 1;
  localparam int STAT_FULL      = 2;
  localparam int STAT_EMPTY     = 3;
  localparam int STAT_OVERFLOW  = 4;
  localparam int STAT_COUNT_LSB = 8;

  typedef struct packed {
    logic [UP_ADDR_WIDTH-1:0] src;
    logic [UP_ADDR_WIDTH-1:0] dst;
    logic [UP_SIZE_WIDTH-1:0] size;
  } up_desc_t;

  typedef enum logic [4:0] {
    DS_IDLE      = 5'b00001,
    DS_LOAD      = 5'b00010,
    DS_ISSUE     = 5'b00100,
    DS_WAIT_BUSY = 5'b01000,
    DS_WAIT_DONE = 5'b10000
  } up_disp_state_e;

endpackage

// File: rtl/up_desc_fifo.sv
// rtl/up_desc_fifo.sv - synchronous descriptor FIFO; full check uses the pre-cycle count
module up_desc_fifo
  import up_regs_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  up_desc_t      push_data_i,
  input  logic          pop_i,
  output up_desc_t      head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  up_desc_t      mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/apb_up_regs.sv
// rtl/apb_up_regs.sv - APB register file, descriptor queue and dispatcher for axi_up_ctrl
module apb_up_regs
  import up_regs_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int ADDR_WIDTH     = UP_ADDR_WIDTH,
  parameter int REG_SIZE_WIDTH = UP_SIZE_WIDTH,
  parameter int QUEUE_DEPTH    = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [ADDR_WIDTH-1:0]     src_addr_o,
  output logic [ADDR_WIDTH-1:0]     dst_addr_o,
  output logic [REG_SIZE_WIDTH-1:0] size_o,
  output logic                      ctrl_int_en_o,
  output logic                      cmd_clr_int_pulse_o,
  output logic                      cmd_trigger_pulse_o,
  input  logic                      status_busy_i,
  input  logic                      status_int_pending_i
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [ADDR_WIDTH-1:0]     src_q, src_d, dst_q, dst_d;
  logic [REG_SIZE_WIDTH-1:0] size_q, size_d;
  logic                      int_en_q, int_en_d, ovf_q, ovf_d, clr_int_q, clr_int_d;

  logic [ADDR_WIDTH-1:0]     out_src_q, out_dst_q;
  logic [REG_SIZE_WIDTH-1:0] out_size_q;
  logic                      trig_q;
  logic [1:0]                wait_cnt_q;
  up_disp_state_e            state_q;

  up_desc_t      fifo_head, push_desc;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0] fifo_count;

  logic [4:0]  reg_off;
  logic        access, wr, mapped, push_req, push_drop;
  logic [31:0] status_word;
  logic        unused_paddr;

  assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};
  assign reg_off   = {PADDR[4:2], 2'b00};
  assign access    = PSEL & PENABLE;
  assign wr        = access & PWRITE;
  assign mapped    = (reg_off <= REG_STATUS);
  assign push_req  = wr & (reg_off == REG_CMD) & PWDATA[CMD_PUSH];
  assign push_drop = push_req & fifo_full;
  assign push_desc = '{src: src_q, dst: dst_q, size: size_q};
  assign fifo_pop  = (state_q == DS_LOAD);

  assign PREADY  = 1'b1;
  assign PSLVERR = access & (~mapped | push_drop);

  always_comb begin
    status_word                             = '0;
    status_word[STAT_BUSY]                  = status_busy_i;
    status_word[STAT_INT_PEND]              = status_int_pending_i;
    status_word[STAT_FULL]                  = fifo_full;
    status_word[STAT_EMPTY]                 = fifo_empty;
    status_word[STAT_OVERFLOW]              = ovf_q;
    status_word[STAT_COUNT_LSB +: CW]       = fifo_count;
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      case (reg_off)
        REG_SRC:    PRDATA = 32'(src_q);
        REG_DST:    PRDATA = 32'(dst_q);
        REG_SIZE:   PRDATA = 32'(size_q);
        REG_CTRL:   PRDATA = {31'b0, int_en_q};
        REG_STATUS: PRDATA = status_word;
        default:    PRDATA = '0;
      endcase
    end
  end

  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    size_d   = size_q;
    int_en_d = int_en_q;
    ovf_d    = ovf_q;
    if (wr) begin
      case (reg_off)
        REG_SRC:    src_d    = PWDATA[ADDR_WIDTH-1:0];
        REG_DST:    dst_d    = PWDATA[ADDR_WIDTH-1:0];
        REG_SIZE:   size_d   = PWDATA[REG_SIZE_WIDTH-1:0];
        REG_CTRL:   int_en_d = PWDATA[0];
        REG_STATUS: if (PWDATA[STAT_OVERFLOW]) ovf_d = 1'b0;
        default:    ;
      endcase
    end
    if (push_drop) ovf_d = 1'b1;
    clr_int_d = wr & (reg_off == REG_CMD) & PWDATA[CMD_CLR_INT];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      src_q     <= '0;
      dst_q     <= '0;
      size_q    <= '0;
      int_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      clr_int_q <= 1'b0;
    end else begin
      src_q     <= src_d;
      dst_q     <= dst_d;
      size_q    <= size_d;
      int_en_q  <= int_en_d;
      ovf_q     <= ovf_d;
      clr_int_q <= clr_int_d;
    end
  end

  up_desc_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk_i       (ACLK),
    .rst_i       (ARESET),
    .push_i      (push_req),
    .push_data_i (push_desc),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Trigger is raised on LOAD->ISSUE so it is high exactly while in ISSUE.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= DS_IDLE;
      trig_q     <= 1'b0;
      wait_cnt_q <= '0;
      out_src_q  <= '0;
      out_dst_q  <= '0;
      out_size_q <= '0;
    end else begin
      trig_q <= 1'b0;
      case (state_q)
        DS_IDLE: if (!fifo_empty && !status_busy_i) state_q <= DS_LOAD;
        DS_LOAD: begin
          out_src_q  <= fifo_head.src;
          out_dst_q  <= fifo_head.dst;
          out_size_q <= fifo_head.size;
          trig_q     <= 1'b1;
          state_q    <= DS_ISSUE;
        end
        DS_ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= DS_WAIT_BUSY;
        end
        DS_WAIT_BUSY: begin
          if (status_busy_i)           state_q <= DS_WAIT_DONE;
          else if (wait_cnt_q == 2'd3) state_q <= DS_IDLE;
          else                         wait_cnt_q <= wait_cnt_q + 2'd1;
        end
        DS_WAIT_DONE: if (!status_busy_i) state_q <= DS_IDLE;
        default: state_q <= DS_IDLE;
      endcase
    end
  end

  assign src_addr_o          = out_src_q;
  assign dst_addr_o          = out_dst_q;
  assign size_o              = out_size_q;
  assign ctrl_int_en_o       = int_en_q;
  assign cmd_clr_int_pulse_o = clr_int_q;
  assign cmd_trigger_pulse_o = trig_q;

endmodule
